rv_regfile_sb: RTL and testbench
================================

# rv_regfile_sb

Parametrised RISC-V integer register file with a built-in pending-write scoreboard, replacing the fixed 32x32, two-read-port register file. It provides NRD combinational read ports, one synchronous write port, a hardwired-zero x0 and optional write-to-read bypass. It also tracks registers awaiting long-latency results (load/mul/div) so the issue stage can stall on RAW hazards. It sits between decode/issue and the writeback stage of the core.

## Interface
- XLEN, 32, register width in bits
- AW, 5, register address width; register count NREG = 2**AW
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value
- MAX_PEND, 4, maximum simultaneously pending registers (1..NREG-1)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rd_addr  in  NRD*AW  read addresses; port k at [k*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port k at [k*XLEN +: XLEN]
- rd_busy  out  NRD  port k addresses a pending register (post-writeback view)
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_data  in  XLEN  write data
- rsv_en  in  1  request to mark rsv_addr pending (long-latency op issuing)
- rsv_addr  in  AW  register to reserve
- rsv_ok  out  1  reservation accepted this cycle
- pend_cnt  out  $clog2(MAX_PEND+1)  number of pending registers
- pend_full  out  1  pend_cnt == MAX_PEND

## Operation
- State: regs[NREG] of XLEN, pending[NREG] bits, pend_cnt counter.
- Reset (async): all regs = 0, pending = 0, pend_cnt = 0. Outputs then read: rd_data = 0, rd_busy = 0, rsv_ok = 0, pend_cnt = 0, pend_full = 0.
- x0: reads always return 0 with rd_busy = 0. Writes to x0 are dropped. Reservations of x0 are rejected (rsv_ok = 0). pending[0] is never set.
- Write: wr_en && wr_addr != 0 sets regs[wr_addr] = wr_data at the edge. wr_clr = wr_en && wr_addr != 0 && pending[wr_addr]; wr_clr clears the pending bit. Writes to non-pending registers are legal and leave pend_cnt unchanged.
- Read port k, addr a:
  - a == 0: data = 0.
  - BYPASS && wr_en && wr_addr == a: data = wr_data.
  - otherwise: data = regs[a].
  - rd_busy[k] = pending[a] && !(wr_clr && wr_addr == a).
- Reservation: rsv_ok = rsv_en && rsv_addr != 0 && both of:
  - the target is free: pending[rsv_addr] is clear, or wr_clr targets it this cycle;
  - capacity exists: pend_cnt < MAX_PEND, or wr_clr is active this cycle.
- On rsv_ok, pending[rsv_addr] is set at the edge. Set wins over a same-cycle clear of the same register.
- Counter: pend_cnt_next = pend_cnt + rsv_ok - wr_clr. It never exceeds MAX_PEND and never goes below 0.
- A rejected reservation has no state effect. The requester holds rsv_en and retries; no internal queueing.

## Timing
- Read: combinational from rd_addr, regs, pending and the same-cycle wr_* inputs. Zero-cycle latency.
- Write: visible in regs one edge after wr_en. Visible same cycle only via bypass (BYPASS = 1).
- rsv_ok is combinational in the same cycle as rsv_en. Pending is visible to rd_busy from the next cycle.
- Reservation and writeback to the same register in one cycle: rsv_ok = 1, the register stays pending, pend_cnt is unchanged.
- Reservation and writeback to different registers while pend_cnt == MAX_PEND: rsv_ok = 1, pend_cnt stays at MAX_PEND.
- rst asserted mid-operation clears all state immediately, independent of clk. In-flight writes and reservations in that cycle are lost.

## Test plan
- Reset:
  - Write 0xDEADBEEF to x5, then pulse rst between edges.
  - Required: reading x5 returns 0 and pend_cnt = 0 before the next clk edge.
- x0 handling:
  - Write 0x12345678 to x0, then reserve x0.
  - Required: read x0 = 0, rd_busy = 0, rsv_ok = 0, pend_cnt = 0.
- Bypass:
  - BYPASS = 1: wr x7 = 0xA5A5A5A5 with rd_addr port1 = 7 in the same cycle; required rd_data = 0xA5A5A5A5.
  - BYPASS = 0: same stimulus; required rd_data = old value, with the new value visible next cycle.
- Capacity:
  - MAX_PEND = 4: reserve x1..x4 in consecutive cycles; required pend_full = 1 and rsv x5 rejected (rsv_ok = 0).
  - Then write x2 and rsv x5 in the same cycle; required rsv_ok = 1, pend_cnt stays 4, rd_busy on x2 = 0 that cycle.
- Same-register overlap:
  - x9 pending; wr x9 = 0x1 and rsv x9 in the same cycle.
  - Required: rsv_ok = 1, read x9 next cycle = 0x1 with rd_busy = 1, pend_cnt unchanged.
- Multi-port, NRD = 4:
  - Write distinct values to x1..x4, then read all four ports simultaneously.
  - Required: each port returns its own register's value, with no cross-port aliasing.

Source files
------------

// File: rtl/rv_regfile_sb_if.sv
// rv_regfile_sb_if: read, write and reservation signals of the scoreboarded register file.
interface rv_regfile_sb_if #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter int NRD      = 2,
   parameter int MAX_PEND = 4
);
   localparam int CW = $clog2(MAX_PEND + 1);
   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_busy;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                rsv_en;
   logic [AW-1:0]       rsv_addr;
   logic                rsv_ok;
   logic [CW-1:0]       pend_cnt;
   logic                pend_full;
   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      input  rd_data, rd_busy, rsv_ok, pend_cnt, pend_full
   );
   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
      output rd_data, rd_busy, rsv_ok, pend_cnt, pend_full
   );
endinterface

// File: rtl/rv_regfile_sb.sv
// rv_regfile_sb: RISC-V integer register file with NRD read ports, one write port
// and a pending-write scoreboard for long-latency results.
module rv_regfile_sb #(
   parameter int XLEN     = 32,
   parameter int AW       = 5,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int MAX_PEND = 4
) (
   input logic clk,
   input logic rst,
   rv_regfile_sb_if.slave bus
);
   localparam int NREG = 2 ** AW;
   localparam int CW   = $clog2(MAX_PEND + 1);

   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] pending, pend_nxt;
   logic [CW-1:0]   cnt;
   logic            wr_act, wr_clr, rsv_free, rsv_room, rsv_ok;

   assign wr_act   = bus.wr_en && bus.wr_addr != '0;
   assign wr_clr   = wr_act && pending[bus.wr_addr];
   // A writeback retiring the same register or any slot frees room this cycle
   assign rsv_free = !pending[bus.rsv_addr] || (wr_clr && bus.wr_addr == bus.rsv_addr);
   assign rsv_room = cnt < CW'(MAX_PEND) || wr_clr;
   assign rsv_ok   = bus.rsv_en && bus.rsv_addr != '0 && rsv_free && rsv_room;

   assign bus.rsv_ok    = rsv_ok;
   assign bus.pend_cnt  = cnt;
   assign bus.pend_full = cnt == CW'(MAX_PEND);

   always_comb begin
      logic [AW-1:0] a;
      bus.rd_data = '0;
      bus.rd_busy = '0;
      for (int k = 0; k < NRD; k++) begin
         a = bus.rd_addr[k*AW +: AW];
         bus.rd_data[k*XLEN +: XLEN] = a == '0 ? '0 :
            (BYPASS != 0 && bus.wr_en && bus.wr_addr == a) ? bus.wr_data : regs[a];
         bus.rd_busy[k] = pending[a] && !(wr_clr && bus.wr_addr == a);
      end
   end

   // Set is applied after clear so a same-cycle re-reservation keeps the bit
   always_comb begin
      pend_nxt = pending;
      if (wr_clr) pend_nxt[bus.wr_addr] = 1'b0;
      if (rsv_ok) pend_nxt[bus.rsv_addr] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending <= '0;
         cnt     <= '0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         pending <= pend_nxt;
         cnt     <= cnt + CW'(rsv_ok) - CW'(wr_clr);
         if (wr_act) regs[bus.wr_addr] <= bus.wr_data;
      end
   end
endmodule

// File: tb/tb_rv_regfile_sb.sv
// tb_rv_regfile_sb: directed table, corner-case sequences and random traffic against
// a behavioural model, on a bypassing and a non-bypassing 4-port instance.
module tb_rv_regfile_sb;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   rv_regfile_sb_if #(.XLEN(32), .AW(5), .NRD(4), .MAX_PEND(4)) b1 ();
   rv_regfile_sb_if #(.XLEN(32), .AW(5), .NRD(4), .MAX_PEND(4)) b0 ();

   rv_regfile_sb #(.XLEN(32), .AW(5), .NRD(4), .BYPASS(1), .MAX_PEND(4)) dut1 (
      .clk(clk), .rst(rst), .bus(b1.slave));
   rv_regfile_sb #(.XLEN(32), .AW(5), .NRD(4), .BYPASS(0), .MAX_PEND(4)) dut0 (
      .clk(clk), .rst(rst), .bus(b0.slave));

   assign b0.rd_addr  = b1.rd_addr;
   assign b0.wr_en    = b1.wr_en;
   assign b0.wr_addr  = b1.wr_addr;
   assign b0.wr_data  = b1.wr_data;
   assign b0.rsv_en   = b1.rsv_en;
   assign b0.rsv_addr = b1.rsv_addr;

   // Reference state: architectural values and the set of registers awaiting writeback
   logic [31:0] mregs [32];
   bit          mpend [32];

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", n, act, exp);
      end
   endtask

   function automatic int pend_count();
      int c = 0;
      for (int i = 0; i < 32; i++) c += int'(mpend[i]);
      return c;
   endfunction

   function automatic logic [19:0] ra4(logic [4:0] a0, logic [4:0] a1, logic [4:0] a2, logic [4:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   function automatic bit retiring(logic [4:0] a);
      return b1.wr_en && b1.wr_addr != 0 && b1.wr_addr == a && mpend[a];
   endfunction

   function automatic logic [31:0] read_val(bit byp, logic [4:0] a);
      if (a == 0) return 32'h0;
      if (byp && b1.wr_en && b1.wr_addr == a) return b1.wr_data;
      return mregs[a];
   endfunction

   function automatic bit rsv_expect();
      bit any_retire = b1.wr_en && b1.wr_addr != 0 && mpend[b1.wr_addr];
      if (!b1.rsv_en || b1.rsv_addr == 0) return 1'b0;
      if (mpend[b1.rsv_addr] && !retiring(b1.rsv_addr)) return 1'b0;
      return pend_count() < 4 || any_retire;
   endfunction

   task automatic model_check();
      logic [4:0] a;
      for (int k = 0; k < 4; k++) begin
         a = b1.rd_addr[k*5 +: 5];
         chk($sformatf("byp_data%0d", k), b1.rd_data[k*32 +: 32], read_val(1'b1, a));
         chk($sformatf("nob_data%0d", k), b0.rd_data[k*32 +: 32], read_val(1'b0, a));
         chk($sformatf("byp_busy%0d", k), 32'(b1.rd_busy[k]), 32'(mpend[a] && !retiring(a)));
         chk($sformatf("nob_busy%0d", k), 32'(b0.rd_busy[k]), 32'(mpend[a] && !retiring(a)));
      end
      chk("rsv_ok", 32'(b1.rsv_ok), 32'(rsv_expect()));
      chk("rsv_ok_nob", 32'(b0.rsv_ok), 32'(rsv_expect()));
      chk("pend_cnt", 32'(b1.pend_cnt), 32'(pend_count()));
      chk("pend_cnt_nob", 32'(b0.pend_cnt), 32'(pend_count()));
      chk("pend_full", 32'(b1.pend_full), 32'(pend_count() == 4));
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         mregs[i] = 32'h0;
         mpend[i] = 1'b0;
      end
   endtask

   task automatic model_step();
      bit ok = rsv_expect();
      if (b1.wr_en && b1.wr_addr != 0) begin
         mregs[b1.wr_addr] = b1.wr_data;
         mpend[b1.wr_addr] = 1'b0;
      end
      if (ok) mpend[b1.rsv_addr] = 1'b1;
   endtask

   task automatic drive(logic we, logic [4:0] wa, logic [31:0] wd, logic re, logic [4:0] ra, logic [19:0] rda);
      @(negedge clk);
      b1.wr_en = we; b1.wr_addr = wa; b1.wr_data = wd;
      b1.rsv_en = re; b1.rsv_addr = ra; b1.rd_addr = rda;
      #1 model_check();
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
   endtask

   task automatic pulse_reset(logic [19:0] rda);
      @(negedge clk);
      b1.wr_en = 0; b1.rsv_en = 0; b1.rd_addr = rda;
      #1 rst = 1'b1;
      #1 chk("rst_data0", b1.rd_data[31:0], 32'h0);
      chk("rst_data0_nob", b0.rd_data[31:0], 32'h0);
      chk("rst_cnt", 32'(b1.pend_cnt), 32'h0);
      #1 rst = 1'b0;
      model_clear();
   endtask

   typedef struct {
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        re;
      logic [4:0]  ra;
      logic [4:0]  r0;
      logic [31:0] exp_d0;
      logic        exp_b0;
      logic        exp_ok;
      int          exp_cnt;
   } vec_t;

   initial begin
      vec_t tbl[6];
      tbl[0] = '{1, 5'd1, 32'h11, 0, 5'd0, 5'd1, 32'h11, 0, 0, 0};
      tbl[1] = '{0, 5'd0, 32'h0,  1, 5'd1, 5'd1, 32'h11, 0, 1, 0};
      tbl[2] = '{0, 5'd0, 32'h0,  1, 5'd1, 5'd1, 32'h11, 1, 0, 1};
      tbl[3] = '{1, 5'd1, 32'h22, 0, 5'd0, 5'd1, 32'h22, 0, 0, 1};
      tbl[4] = '{0, 5'd0, 32'h0,  1, 5'd0, 5'd1, 32'h22, 0, 0, 0};
      tbl[5] = '{1, 5'd0, 32'h99, 1, 5'd2, 5'd0, 32'h0,  0, 1, 0};
      model_clear();
      b1.wr_en = 0; b1.wr_addr = 0; b1.wr_data = 0;
      b1.rsv_en = 0; b1.rsv_addr = 0; b1.rd_addr = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      chk("reset_data", b1.rd_data[31:0], 32'h0);
      chk("reset_busy", 32'(b1.rd_busy), 32'h0);
      chk("reset_rsv_ok", 32'(b1.rsv_ok), 32'h0);
      chk("reset_full", 32'(b1.pend_full), 32'h0);
      tick();

      for (int i = 0; i < 6; i++) begin
         drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].re, tbl[i].ra, ra4(tbl[i].r0, 0, 0, 0));
         chk($sformatf("tbl%0d_data", i), b1.rd_data[31:0], tbl[i].exp_d0);
         chk($sformatf("tbl%0d_busy", i), 32'(b1.rd_busy[0]), 32'(tbl[i].exp_b0));
         chk($sformatf("tbl%0d_rsv_ok", i), 32'(b1.rsv_ok), 32'(tbl[i].exp_ok));
         chk($sformatf("tbl%0d_cnt", i), 32'(b1.pend_cnt), 32'(tbl[i].exp_cnt));
         tick();
      end

      // Asynchronous reset between edges
      pulse_reset(0);
      drive(1, 5'd5, 32'hDEADBEEF, 1, 5'd6, 0); tick();
      drive(0, 0, 0, 0, 0, ra4(5, 0, 0, 0));
      chk("pre_rst_x5", b1.rd_data[31:0], 32'hDEADBEEF);
      chk("pre_rst_cnt", 32'(b1.pend_cnt), 32'd1);
      pulse_reset(ra4(5, 0, 0, 0));

      // x0 is hardwired and never reservable
      drive(1, 5'd0, 32'h12345678, 0, 0, 0); tick();
      drive(0, 0, 0, 1, 5'd0, 0);
      chk("x0_data", b1.rd_data[31:0], 32'h0);
      chk("x0_busy", 32'(b1.rd_busy[0]), 32'h0);
      chk("x0_rsv_ok", 32'(b1.rsv_ok), 32'h0);
      chk("x0_cnt", 32'(b1.pend_cnt), 32'h0);
      tick();

      // Same-cycle bypass versus stored value
      drive(1, 5'd7, 32'h11111111, 0, 0, 0); tick();
      drive(1, 5'd7, 32'hA5A5A5A5, 0, 0, ra4(0, 7, 0, 0));
      chk("bypass_on", b1.rd_data[63:32], 32'hA5A5A5A5);
      chk("bypass_off", b0.rd_data[63:32], 32'h11111111);
      tick();
      drive(0, 0, 0, 0, 0, ra4(0, 7, 0, 0));
      chk("bypass_off_next", b0.rd_data[63:32], 32'hA5A5A5A5);
      tick();

      // Capacity limit and retire-and-reserve at full
      pulse_reset(0);
      for (int r = 1; r <= 4; r++) begin
         drive(0, 0, 0, 1, 5'(r), 0); tick();
      end
      drive(0, 0, 0, 1, 5'd5, 0);
      chk("cap_full", 32'(b1.pend_full), 32'h1);
      chk("cap_reject", 32'(b1.rsv_ok), 32'h0);
      tick();
      drive(1, 5'd2, 32'h2, 1, 5'd5, ra4(2, 0, 0, 0));
      chk("cap_swap_ok", 32'(b1.rsv_ok), 32'h1);
      chk("cap_swap_busy", 32'(b1.rd_busy[0]), 32'h0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      chk("cap_swap_cnt", 32'(b1.pend_cnt), 32'd4);
      tick();

      // Retire and re-reserve the same register
      pulse_reset(0);
      drive(0, 0, 0, 1, 5'd9, 0); tick();
      drive(1, 5'd9, 32'h1, 1, 5'd9, 0);
      chk("same_rsv_ok", 32'(b1.rsv_ok), 32'h1);
      tick();
      drive(0, 0, 0, 0, 0, ra4(9, 0, 0, 0));
      chk("same_data", b1.rd_data[31:0], 32'h1);
      chk("same_busy", 32'(b1.rd_busy[0]), 32'h1);
      chk("same_cnt", 32'(b1.pend_cnt), 32'd1);
      tick();

      // Four ports read four distinct registers at once
      for (int r = 1; r <= 4; r++) begin
         drive(1, 5'(r), 32'hC0DE0000 + 32'(r), 0, 0, 0); tick();
      end
      drive(0, 0, 0, 0, 0, ra4(1, 2, 3, 4));
      for (int k = 0; k < 4; k++)
         chk($sformatf("mport%0d", k), b0.rd_data[k*32 +: 32], 32'hC0DE0001 + 32'(k));
      tick();

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 79) == 0) pulse_reset(0);
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               ra4(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))));
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
